tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler_pkg.sv | 15 +
 rtl/tick_scheduler_if.sv | 25 ++
 rtl/tick_prescaler.sv | 49 ++++
 rtl/tick_scheduler.sv | 102 ++++++++++
 tb/tb_tick_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: channel count, rate encoding, channel FSM states.
package tick_sched_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam logic RATE_4HZ = 1'b0;
  localparam logic RATE_1HZ = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } ch_state_e;

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration handshake, per-channel stop requests and per-channel status/pulse outputs.
interface tick_scheduler_if;
  import tick_sched_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic              cfg_rate;
  logic [7:0]        cfg_count;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_done;

  modport master (
    output cfg_valid, cfg_ch, cfg_rate, cfg_count, stop,
    input  cfg_ready, ch_tick, ch_busy, ch_done
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_rate, cfg_count, stop,
    output cfg_ready, ch_tick, ch_busy, ch_done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running base-tick prescaler producing 4 Hz / 1 Hz strobes and, when
// TICK_SCHED_SQUARE_OUT_EN is defined, matching 50% duty square waves (tied low otherwise).
module tick_prescaler #(
  parameter int unsigned BASE_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic s4,
  output logic s1,
  output logic clk_4hz,
  output logic clk_1hz
);

  localparam int unsigned CntW = $clog2(BASE_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BASE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      phase_q, phase_d;

  always_comb begin
    s4      = (cnt_q == CntMax);
    s1      = s4 && (phase_q == 2'd3);
    cnt_d   = s4 ? '0 : cnt_q + CntW'(1);
    phase_d = s4 ? phase_q + 2'd1 : phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

`ifdef TICK_SCHED_SQUARE_OUT_EN
  localparam logic [CntW-1:0] CntHalf = CntW'(BASE_DIV / 2);

  always_comb begin
    clk_4hz = (cnt_q >= CntHalf);
    clk_1hz = phase_q[1];
  end
`else
  assign clk_4hz = 1'b0;
  assign clk_1hz = 1'b0;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// Four independent tick channels driven by a shared free-running prescaler.
// Square-wave outputs are present only when TICK_SCHED_SQUARE_OUT_EN is defined.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned BASE_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  tick_scheduler_if.slave  bus,
  output logic             clk_4hz,
  output logic             clk_1hz
);

  logic s4, s1;

  tick_prescaler #(
    .BASE_DIV(BASE_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .s4      (s4),
    .s1      (s1),
    .clk_4hz (clk_4hz),
    .clk_1hz (clk_1hz)
  );

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [7:0]        rem_q   [NUM_CH];
  logic [7:0]        rem_d   [NUM_CH];
  logic [NUM_CH-1:0] rate_q, rate_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] busy, done, strobe, accept;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]   = (state_q[i] == StRun);
      done[i]   = (state_q[i] == StDone);
      strobe[i] = (rate_q[i] == RATE_1HZ) ? s1 : s4;
    end
  end

  assign bus.cfg_ready = ~busy[bus.cfg_ch];
  assign accept = (bus.cfg_valid && bus.cfg_ready) ? (NUM_CH'(1) << bus.cfg_ch) : '0;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      rate_d[i]  = rate_q[i];
      tick_d[i]  = 1'b0;
      unique case (state_q[i])
        StIdle, StDone: begin
          state_d[i] = StIdle;
          if (accept[i]) begin
            state_d[i] = StRun;
            rate_d[i]  = bus.cfg_rate;
            rem_d[i]   = bus.cfg_count;
          end
        end
        StRun: begin
          // Stop wins over a coincident strobe: no tick, no done.
          if (bus.stop[i]) begin
            state_d[i] = StIdle;
          end else if (strobe[i]) begin
            tick_d[i] = 1'b1;
            if (rem_q[i] == 8'd1) begin
              state_d[i] = StDone;
            end else if (rem_q[i] != 8'd0) begin
              rem_d[i] = rem_q[i] - 8'd1;
            end
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        rem_q[i]   <= 8'd0;
      end
      rate_q <= {NUM_CH{RATE_4HZ}};
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      rate_q <= rate_d;
      tick_q <= tick_d;
    end
  end

  assign bus.ch_tick = tick_q;
  assign bus.ch_busy = busy;
  assign bus.ch_done = done;

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomised scoreboard bench for tick_scheduler with a cycle-arithmetic reference model.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int unsigned BD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clk_4hz, clk_1hz;

  tick_scheduler_if bus ();

  tick_scheduler #(
    .BASE_DIV(BD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .clk_4hz (clk_4hz),
    .clk_1hz (clk_1hz)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n     = 0;  // rising edges seen since reset release

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  typedef struct {
    int unsigned at;
    logic [3:0]  tick;
    logic [3:0]  done;
  } exp_t;

  exp_t sb[$];

  bit m_busy [4];
  int m_rem  [4];
  bit m_rate [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = m_busy[i];
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0;
      m_rem[i]  = 0;
      m_rate[i] = 0;
    end
    sb.delete();
  endtask

  // One clock cycle: drive inputs, check level outputs, advance the model.
  task automatic step(input bit v, input int ch, input bit rate, input int cnt,
                      input logic [3:0] stp);
    logic [3:0] nt, nd;
    bit s4, s1;
    @(negedge clk);
    #1;
    bus.cfg_valid = v;
    bus.cfg_ch    = ch[1:0];
    bus.cfg_rate  = rate;
    bus.cfg_count = cnt[7:0];
    bus.stop      = stp;
    #1;
    check("ch_busy", {28'd0, bus.ch_busy}, {28'd0, model_busy()});
    if (v) check("cfg_ready", {31'd0, bus.cfg_ready}, {31'd0, !m_busy[ch]});
    s4 = (n % BD) == BD - 1;
    s1 = (n % (4 * BD)) == 4 * BD - 1;
    nt = '0;
    nd = '0;
    for (int i = 0; i < 4; i++) begin
      bit str;
      str = m_rate[i] ? s1 : s4;
      if (m_busy[i]) begin
        if (stp[i]) begin
          m_busy[i] = 0;
        end else if (str) begin
          nt[i] = 1'b1;
          if (m_rem[i] == 1) begin
            m_busy[i] = 0;
            nd[i]     = 1'b1;
          end else if (m_rem[i] > 1) begin
            m_rem[i]--;
          end
        end
      end else if (v && ch == i) begin
        m_busy[i] = 1;
        m_rate[i] = rate;
        m_rem[i]  = cnt;
      end
    end
    if ((nt | nd) != 4'd0) sb.push_back('{at: n + 1, tick: nt, done: nd});
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(0, 0, 0, 0, 4'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ch_tick", {28'd0, bus.ch_tick}, 32'd0);
    check("rst_ch_busy", {28'd0, bus.ch_busy}, 32'd0);
    check("rst_ch_done", {28'd0, bus.ch_done}, 32'd0);
    check("rst_clk_4hz", {31'd0, clk_4hz}, 32'd0);
    check("rst_clk_1hz", {31'd0, clk_1hz}, 32'd0);
    check("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.stop      = 4'd0;
    rst_n         = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops expected pulses when the DUT presents them; checks square waves each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].at < n) begin
          check("missed_event", n, sb[0].at);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].at == n) begin
          e = sb.pop_front();
          check("ch_tick", {28'd0, bus.ch_tick}, {28'd0, e.tick});
          check("ch_done", {28'd0, bus.ch_done}, {28'd0, e.done});
        end else if ((bus.ch_tick | bus.ch_done) != 4'd0) begin
          check("unexpected_event", {24'd0, bus.ch_tick, bus.ch_done}, 32'd0);
        end
`ifdef TICK_SCHED_SQUARE_OUT_EN
        check("clk_4hz", {31'd0, clk_4hz}, {31'd0, (n % BD) >= BD / 2});
        check("clk_1hz", {31'd0, clk_1hz}, {31'd0, ((n / BD) % 4) >= 2});
`else
        check("clk_4hz_off", {31'd0, clk_4hz}, 32'd0);
        check("clk_1hz_off", {31'd0, clk_1hz}, 32'd0);
`endif
      end
    end
  end

  initial begin : stimulus
    int k;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = 2'd0;
    bus.cfg_rate  = 1'b0;
    bus.cfg_count = 8'd0;
    bus.stop      = 4'd0;
    model_clear();
    #2;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Finite run: three 4 Hz ticks then done.
    step(1, 0, RATE_4HZ, 3, 4'd0);
    idle(40);

    // Continuous 1 Hz run, stopped after several ticks.
    step(1, 1, RATE_1HZ, 0, 4'd0);
    idle(4 * 32 + 8);
    step(0, 0, 0, 0, 4'b0010);
    idle(3);

    // Busy channel refuses config; an idle channel accepts.
    step(1, 2, RATE_4HZ, 0, 4'd0);
    idle(2);
    step(1, 2, RATE_1HZ, 5, 4'd0);
    step(1, 3, RATE_4HZ, 2, 4'd0);
    idle(20);
    step(0, 0, 0, 0, 4'b0100);
    idle(30);

    // Stop landing exactly on a base-tick strobe.
    step(1, 0, RATE_4HZ, 0, 4'd0);
    idle(10);
    k = 0;
    while (((n + 1) % BD) != BD - 1 && k < 16) begin
      idle(1);
      k++;
    end
    step(0, 0, 0, 0, 4'b0001);
    idle(12);

    // Reset in the middle of a run.
    step(1, 0, RATE_4HZ, 2, 4'd0);
    idle(9);
    pulse_reset();
    idle(40);

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      logic [3:0] stp;
      for (int b = 0; b < 4; b++) stp[b] = ($urandom_range(0, 99) < 3);
      step($urandom_range(0, 99) < 30, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 4)), stp);
    end

    step(0, 0, 0, 0, 4'hF);
    idle(40);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
